// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM.
//   - read-during-write mode encodings
//   - clear-sequencer state enum
//   - nbytes(): byte-lane count for a word width
//   - merge_bytes(): byte-lane merge of a new word over an old word
// The merge works on a fixed maximum width. Callers zero-extend their
// operands into it and truncate the result back to their own width.
package dual_port_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word merge_bytes can handle
  localparam int MAX_W  = 512;
  localparam int MAX_NB = MAX_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

  // Lanes with be[i]=1 take new_w, all other lanes keep old_w
  function automatic logic [MAX_W-1:0] merge_bytes(
    input logic [MAX_W-1:0]  old_w,
    input logic [MAX_W-1:0]  new_w,
    input logic [MAX_NB-1:0] be
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_NB; i++)
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Memory-clear sequencer for dual_port_ram_param.
// After reset, walks every word address once and emits a write strobe
// that the top muxes ahead of port A. busy_o covers exactly DEPTH cycles
// after rst drops. A reset in the middle of the walk starts it again at 0.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   busy_o        high while the clear walk is running
//   clr_we_o      clear write strobe (same as busy_o)
//   clr_addr_o    word address being cleared this cycle
module dpram_clear_ctrl
  import dual_port_ram_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      CLEAR: begin
        // The last address is written on the same edge that leaves CLEAR
        if (addr_q == LAST_ADDR) state_d = RUN;
        else                     addr_d  = addr_q + 1'b1;
      end
      RUN:     ;
      default: state_d = RUN;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = addr_q;

endmodule

// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM, single clock.
// Two independent masters share one array. Each port supports byte enables,
// a read-during-write mode, and an optional output register. Writes from
// both ports to the same word in one cycle are merged lane by lane, and the
// priority port wins any overlapping lanes. After reset the array can be
// zero-filled by dpram_clear_ctrl, which takes over port A's write path.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   en_x, we_x, be_x, addr_x, data_x port x request (x = a, b)
//   q_a, q_b                         read data (registered)
//   busy                             clear sequence running, requests ignored
//   collision                        same-address conflict seen (one cycle)
module dual_port_ram_param
  import dual_port_ram_pkg::*;
#(
  parameter  int DATA_W         = 16,
  parameter  int DEPTH          = 64,
  parameter  int RDW_MODE       = 0,
  parameter  int OUT_REG        = 0,
  parameter  int CLEAR_ON_RESET = 1,
  parameter  int PRIORITY_A     = 1,
  localparam int ADDR_W         = $clog2(DEPTH),
  localparam int NB             = nbytes(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [NB-1:0]     be_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [NB-1:0]     be_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              busy,
  output logic              collision
);

  // One bit wider than the address so the compare works for any DEPTH
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Qualified per-port request, decoded once from the raw inputs
  typedef struct packed {
    logic              en;    // enabled and not blocked by reset/clear
    logic              inr;   // address inside the array
    logic              act;   // en && inr
    logic              wr;    // act && we
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] old_w; // array word before this edge
    logic [DATA_W-1:0] new_w; // old_w with this port's lanes merged in
  } port_req_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy_w;

  dpram_clear_ctrl #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk        (clk),
    .rst        (rst),
    .busy_o     (busy_w),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign busy = busy_w;

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    return DATA_W'(merge_bytes(MAX_W'(old_w), MAX_W'(new_w), MAX_NB'(be)));
  endfunction

  port_req_t ra, rb;
  logic      run;
  logic      same_addr;
  logic      coll_d;

  // Array write channels: w0 is port A (or the clear walk), w1 is port B
  logic              w0_en, w1_en;
  logic [ADDR_W-1:0] w0_addr, w1_addr;
  logic [DATA_W-1:0] w0_data, w1_data;

  always_comb begin
    run = !rst && !busy_w;

    ra.en    = run && en_a;
    ra.inr   = ({1'b0, addr_a} < DEPTH_L);
    ra.act   = ra.en && ra.inr;
    ra.wr    = ra.act && we_a;
    ra.addr  = addr_a;
    ra.old_w = ra.inr ? mem[addr_a] : '0;
    ra.new_w = merge_w(ra.old_w, data_a, be_a);

    rb.en    = run && en_b;
    rb.inr   = ({1'b0, addr_b} < DEPTH_L);
    rb.act   = rb.en && rb.inr;
    rb.wr    = rb.act && we_b;
    rb.addr  = addr_b;
    rb.old_w = rb.inr ? mem[addr_b] : '0;
    rb.new_w = merge_w(rb.old_w, data_b, be_b);

    // Out-of-range ports never get here because act already excludes them
    same_addr = ra.act && rb.act && (addr_a == addr_b);
    coll_d    = same_addr && (we_a || we_b);
  end

  always_comb begin
    w0_en   = ra.wr;
    w0_addr = ra.addr;
    w0_data = ra.new_w;
    w1_en   = rb.wr;
    w1_addr = rb.addr;
    w1_data = rb.new_w;

    // Write/write on one word: collapse both into a single write. The
    // loser's lanes go in first and the winner's lanes go over them, so
    // non-overlapping lanes from both ports survive.
    if (same_addr && ra.wr && rb.wr) begin
      if (PRIORITY_A != 0) w0_data = merge_w(rb.new_w, data_a, be_a);
      else                 w0_data = merge_w(ra.new_w, data_b, be_b);
      w1_en = 1'b0;
    end

    // Ports are idle while busy, so the clear walk can use port A's path
    if (clr_we && !rst) begin
      w0_en   = 1'b1;
      w0_addr = clr_addr;
      w0_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w1_en) mem[w1_addr] <= w1_data;
    if (w0_en) mem[w0_addr] <= w0_data;
  end

  // First read stage, shared logic for both ports
  function automatic logic [DATA_W-1:0] rd_next(
    input port_req_t         r,
    input logic              we,
    input logic [DATA_W-1:0] cur
  );
    logic [DATA_W-1:0] nx;
    nx = cur;
    if (r.en) begin
      if (!r.inr)                        nx = '0;
      // A read, including the reading side of a collision, sees the old word
      else if (!we)                      nx = r.old_w;
      else if (RDW_MODE == RDW_READ_FIRST)  nx = r.old_w;
      else if (RDW_MODE == RDW_WRITE_FIRST) nx = r.new_w;
      else                               nx = cur;
    end
    return nx;
  endfunction

  logic [DATA_W-1:0] q1a_q, q1a_d, q1b_q, q1b_d;
  logic              coll_q;

  always_comb begin
    q1a_d = rd_next(ra, we_a, q1a_q);
    q1b_d = rd_next(rb, we_b, q1b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1a_q  <= '0;
      q1b_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      q1a_q  <= q1a_d;
      q1b_q  <= q1b_d;
      coll_q <= coll_d;
    end
  end

  // The collision flag stays aligned with the first stage, even with OUT_REG
  assign collision = coll_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] q2a_q, q2b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          q2a_q <= '0;
          q2b_q <= '0;
        end else begin
          q2a_q <= q1a_q;
          q2b_q <= q1b_q;
        end
      end
      assign q_a = q2a_q;
      assign q_b = q2b_q;
    end else begin : g_noreg
      assign q_a = q1a_q;
      assign q_b = q1b_q;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param. Three instances share one stimulus:
//   u0: defaults (READ_FIRST, no output reg, A priority, DEPTH 64)
//   u1: DEPTH 48, WRITE_FIRST, OUT_REG=1, B priority
//   u2: NO_CHANGE, otherwise defaults
module tb_dual_port_ram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;

  logic [15:0] qa [3];
  logic [15:0] qb [3];
  logic        bsy [3];
  logic        col [3];

  int n_chk  = 0;
  int n_pass = 0;
  int cnt [3];

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(16), .DEPTH(64), .RDW_MODE(0), .OUT_REG(0),
                        .CLEAR_ON_RESET(1), .PRIORITY_A(1)) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb[0]),
    .busy(bsy[0]), .collision(col[0]));

  dual_port_ram_param #(.DATA_W(16), .DEPTH(48), .RDW_MODE(1), .OUT_REG(1),
                        .CLEAR_ON_RESET(1), .PRIORITY_A(0)) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb[1]),
    .busy(bsy[1]), .collision(col[1]));

  dual_port_ram_param #(.DATA_W(16), .DEPTH(64), .RDW_MODE(2), .OUT_REG(0),
                        .CLEAR_ON_RESET(1), .PRIORITY_A(1)) u2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb[2]),
    .busy(bsy[2]), .collision(col[2]));

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pa(input logic e, input logic w, input logic [1:0] b,
                    input logic [5:0] a, input logic [15:0] d);
    en_a = e; we_a = w; be_a = b; addr_a = a; data_a = d;
  endtask

  task automatic pb(input logic e, input logic w, input logic [1:0] b,
                    input logic [5:0] a, input logic [15:0] d);
    en_b = e; we_b = w; be_b = b; addr_b = a; data_b = d;
  endtask

  task automatic idle();
    pa(1'b0, 1'b0, 2'b00, 6'h00, 16'h0000);
    pb(1'b0, 1'b0, 2'b00, 6'h00, 16'h0000);
  endtask

  // Samples busy right after the last reset edge, then on 69 more edges
  task automatic count_busy();
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    repeat (70) begin
      for (int k = 0; k < 3; k++) if (bsy[k]) cnt[k]++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_busy",  16'(bsy[0]), 16'h0001);
    chk("rst_qa",    qa[0], 16'h0000);
    chk("rst_qb",    qb[0], 16'h0000);
    chk("rst_coll",  16'(col[0]), 16'h0000);
    rst = 1'b0;
    count_busy();
    chk("clr_cnt_d64", 16'(cnt[0]), 16'd64);
    chk("clr_cnt_d48", 16'(cnt[1]), 16'd48);
    chk("clr_done",    16'(bsy[0]), 16'h0000);

    // Cleared contents; both ports reading one word is not a collision
    pa(1'b1, 1'b0, 2'b11, 6'h00, 16'h0); pb(1'b1, 1'b0, 2'b11, 6'h1F, 16'h0); tick();
    chk("clr_rd00", qa[0], 16'h0000);
    chk("clr_rd1f", qb[0], 16'h0000);
    pa(1'b1, 1'b0, 2'b11, 6'h3F, 16'h0); pb(1'b1, 1'b0, 2'b11, 6'h3F, 16'h0); tick();
    chk("clr_rd3f_a", qa[0], 16'h0000);
    chk("clr_rd3f_b", qb[0], 16'h0000);
    chk("rr_nocoll", 16'(col[0]), 16'h0000);

    // Crossed dual write then read
    pa(1'b1, 1'b1, 2'b11, 6'h01, 16'h1234); pb(1'b1, 1'b1, 2'b11, 6'h02, 16'h5678); tick();
    chk("ww_diff_nocoll", 16'(col[0]), 16'h0000);
    pa(1'b1, 1'b0, 2'b11, 6'h02, 16'h0); pb(1'b1, 1'b0, 2'b11, 6'h01, 16'h0); tick();
    chk("cross_qa",     qa[0], 16'h5678);
    chk("cross_qb",     qb[0], 16'h1234);
    chk("cross_nc_qa",  qa[2], 16'h5678);
    chk("wf_oreg_qa",   qa[1], 16'h1234);
    chk("wf_oreg_qb",   qb[1], 16'h5678);
    idle(); tick();
    chk("oreg_qa",      qa[1], 16'h5678);
    chk("oreg_qb",      qb[1], 16'h1234);
    chk("en0_hold",     qa[0], 16'h5678);

    // Byte enables
    pa(1'b1, 1'b1, 2'b11, 6'h05, 16'hAAAA); tick();
    chk("nc_hold_wr",   qa[2], 16'h5678);
    pa(1'b1, 1'b1, 2'b01, 6'h05, 16'h5555); tick();
    pa(1'b1, 1'b0, 2'b11, 6'h05, 16'h0); tick();
    chk("be_rd",        qa[0], 16'hAA55);
    chk("be_wf_merged", qa[1], 16'hAA55);
    chk("be_rd_nc",     qa[2], 16'hAA55);

    // Read-during-write modes
    pa(1'b1, 1'b1, 2'b11, 6'h07, 16'h1111); tick();
    pa(1'b1, 1'b1, 2'b11, 6'h07, 16'h2222); tick();
    chk("rdw_rf",       qa[0], 16'h1111);
    chk("rdw_nc",       qa[2], 16'hAA55);
    chk("rdw_wf_prev",  qa[1], 16'h1111);
    idle(); tick();
    chk("rdw_wf",       qa[1], 16'h2222);

    // Write/write collision
    pa(1'b1, 1'b1, 2'b11, 6'h0A, 16'hAAAA); pb(1'b1, 1'b1, 2'b10, 6'h0A, 16'hBBBB); tick();
    chk("ww_coll_u0",   16'(col[0]), 16'h0001);
    chk("ww_coll_oreg", 16'(col[1]), 16'h0001);
    idle(); tick();
    chk("ww_coll_1cyc", 16'(col[0]), 16'h0000);
    pa(1'b1, 1'b0, 2'b11, 6'h0A, 16'h0); tick();
    chk("ww_pria",      qa[0], 16'hAAAA);
    chk("ww_pria_u2",   qa[2], 16'hAAAA);
    idle(); tick();
    chk("ww_prib",      qa[1], 16'hBBAA);

    // Write/read collision: reader sees old word
    pa(1'b1, 1'b1, 2'b11, 6'h0A, 16'hCCCC); pb(1'b1, 1'b0, 2'b11, 6'h0A, 16'h0); tick();
    chk("wr_coll",      16'(col[0]), 16'h0001);
    chk("wr_old_qb",    qb[0], 16'hAAAA);
    chk("wr_rf_qa",     qa[0], 16'hAAAA);
    chk("wr_coll_u1",   16'(col[1]), 16'h0001);
    idle(); tick();
    chk("wr_old_qb_u1", qb[1], 16'hBBAA);
    pa(1'b1, 1'b0, 2'b11, 6'h0A, 16'h0); tick();
    chk("wr_new",       qa[0], 16'hCCCC);

    // Out of range on DEPTH=48 (0x30); in range on DEPTH=64
    pa(1'b1, 1'b1, 2'b11, 6'h30, 16'hDEAD); pb(1'b1, 1'b0, 2'b11, 6'h30, 16'h0); tick();
    chk("oor_coll_d64", 16'(col[0]), 16'h0001);
    chk("oor_coll_d48", 16'(col[1]), 16'h0000);
    chk("oor_qb_d64",   qb[0], 16'h0000);
    pa(1'b1, 1'b0, 2'b11, 6'h30, 16'h0); pb(1'b0, 1'b0, 2'b00, 6'h00, 16'h0); tick();
    chk("oor_rd_d64",   qa[0], 16'hDEAD);
    idle(); tick();
    chk("oor_rd_d48",   qa[1], 16'h0000);

    // Reset 20 cycles into a clear restarts it from address 0
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (20) tick();
    rst = 1'b1; tick();
    chk("rst2_qa",   qa[0], 16'h0000);
    chk("rst2_coll", 16'(col[0]), 16'h0000);
    chk("rst2_busy", 16'(bsy[1]), 16'h0001);
    rst = 1'b0;
    count_busy();
    chk("reclr_cnt_d64", 16'(cnt[0]), 16'd64);
    chk("reclr_cnt_d48", 16'(cnt[1]), 16'd48);
    chk("reclr_cnt_u2",  16'(cnt[2]), 16'd64);

    pa(1'b1, 1'b1, 2'b11, 6'h3C, 16'h7777); tick();
    pa(1'b1, 1'b0, 2'b11, 6'h3C, 16'h0); tick();
    chk("post_wr",   qa[0], 16'h7777);
    pa(1'b1, 1'b0, 2'b11, 6'h05, 16'h0); tick();
    chk("post_clr",  qa[0], 16'h0000);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
- Parametrised true dual-port synchronous RAM: next generation of the team's 8-bit x 64 dual_port_ram.
- Adds configurable width and depth, per-port enable and byte enables, and selectable read-during-write mode.
- Adds an optional output pipeline register, deterministic same-address collision handling, and a reset-triggered memory-clear sequencer.
- Used as a shared buffer between two independent masters in the same clock domain.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- RDW_MODE, 0, same-port read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE. Applies to both ports.
- OUT_REG, 0, 1 adds one output register stage on q_a/q_b.
- CLEAR_ON_RESET, 1, 1 zero-fills the whole array after reset.
- PRIORITY_A, 1, 1 gives port A the win on a same-byte write-write collision; 0 gives it to port B.

Ports:
- clk  input  1  single clock; all activity on the rising edge
- rst  input  1  synchronous, active-high reset
- en_a  input  1  port A access enable
- we_a  input  1  port A write enable; qualified by en_a
- be_a  input  NB  port A byte enables; qualified by we_a
- addr_a  input  ADDR_W  port A address
- data_a  input  DATA_W  port A write data
- q_a  output  DATA_W  port A read data
- en_b / we_b / be_b / addr_b / data_b / q_b  same widths and meanings for port B
- busy  output  1  high while the clear sequence runs; port requests are ignored
- collision  output  1  one-cycle flag: same-address conflict detected

Behaviour:
- Reset: rst sampled high at an edge gives q_a=0, q_b=0, collision=0, ppln regs=0.
  - CLEAR_ON_RESET=1: FSM enters CLEAR, clr_addr=0, busy=1.
  - CLEAR_ON_RESET=0: FSM enters RUN, busy=0, memory contents preserved.
- rst asserted mid-clear restarts the clear at address 0.
- FSM states:
  - CLEAR: writes 0 to mem[clr_addr] each cycle, clr_addr++. On clr_addr==DEPTH-1, go to RUN; busy drops at the following edge.
  - Exactly DEPTH busy cycles after rst deasserts. en/we inputs are ignored; q holds 0.
  - RUN: normal access; stays there until rst.
- Port operation in RUN, per port, at edge N with en=1:
  - Write: we=1 updates only the byte lanes with be[i]=1.
  - Read data appears on q at edge N (visible cycle N+1) when OUT_REG=0, and one edge later when OUT_REG=1.
  - en=0: q holds its previous value; no write.
- Same-port read-during-write (en=1, we=1):
  - READ_FIRST: q = old word.
  - WRITE_FIRST: q = merged new word; disabled lanes show old bytes.
  - NO_CHANGE: q holds.
- Cross-port collision: en_a, en_b both 1, addr_a==addr_b, and at least one we.
  - collision=1 aligned with first-stage read data, i.e. edge N; it is not delayed by OUT_REG.
  - Write/write: non-overlapping byte lanes from both ports are applied. Overlapping lanes take the PRIORITY_A winner.
  - Write/read: the reading port always gets the old word, regardless of RDW_MODE.
  - Both read: no collision flagged.
- Out-of-range address (addr >= DEPTH, possible when DEPTH is not a power of two): write dropped, read returns 0, no collision flagged for that port.
- No combinational path from any input to any output.

Decomposition:
- Package dual_port_ram_pkg:
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2.
  - FSM state enum {CLEAR, RUN}.
  - Function nbytes(DATA_W).
  - Function merge_bytes(old, new, be) for byte-lane merging.
- Sub-module dpram_clear_ctrl: owns the CLEAR/RUN FSM, clr_addr counter and busy. Outputs a clear write strobe and address that the top muxes ahead of port A.
- Array, port logic, collision resolution and output stage stay in the top module.

Test Plan:
- Clear sequence (defaults): hold rst 2 cycles then release -> busy=1 for exactly 64 cycles, then 0. Afterwards, reads of 0x00, 0x1F, 0x3F on both ports return 0x0000.
- Basic dual write/read: A writes 0x1234 to 0x01 and B writes 0x5678 to 0x02 in the same cycle. Next cycle both read crossed addresses -> q_a=0x5678, q_b=0x1234. With OUT_REG=1 the values appear one cycle later.
- Byte enables: write 0xAAAA to 0x05 with be=2'b11, then 0x5555 with be=2'b01, then read -> 0xAA55.
- RDW modes: mem[0x07]=0x1111, A writes 0x2222 to 0x07 with en=1.
  - RDW_MODE=0 -> q_a=0x1111.
  - RDW_MODE=1 -> q_a=0x2222.
  - RDW_MODE=2 -> q_a keeps its prior value.
- Collision: both ports write 0x0A, A=0xAAAA be=11, B=0xBBBB be=10.
  - PRIORITY_A=1 -> collision=1 for one cycle, mem=0xAAAA.
  - PRIORITY_A=0 -> mem=0xBBAA.
  - A writes 0xCCCC while B reads 0x0A -> q_b shows the old word, collision=1.
- Boundaries: with DEPTH=48, a write to 0x30 is dropped and a read of it returns 0. Asserting rst at clear cycle 20 -> busy stays high for 48 cycles after the new release.
